// File: rtl/examp2_operand_pair_loader_if.sv
// Stream-in / pair-out bundle for the operand pair loader.
// The slave modport is the loader's view; the master modport is the producer/consumer side.
interface examp2_operand_pair_loader_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   data_in_valid;
  logic                   data_in_ready;
  logic [DATA_WIDTH-1:0]  first_data_out;
  logic [DATA_WIDTH-1:0]  second_data_out;
  logic                   pair_valid;
  logic                   pair_ready;
  logic [COUNT_WIDTH-1:0] pair_count;

  modport slave (
    input  data_in, data_in_valid, pair_ready,
    output data_in_ready, first_data_out, second_data_out, pair_valid, pair_count
  );

  modport master (
    output data_in, data_in_valid, pair_ready,
    input  data_in_ready, first_data_out, second_data_out, pair_valid, pair_count
  );
endinterface

// File: rtl/examp2_operand_pair_loader.sv
// Pairs consecutive stream beats into registered first/second operands held until accepted.
// Optional hand-off counter is built only when PAIR_COUNT_EN is defined.
module examp2_operand_pair_loader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                        system_clock,
  input  logic                        system_rst_n,
  input  logic                        flush,
  examp2_operand_pair_loader_if.slave bus,
  output logic [1:0]                  state_dbg
);

  typedef enum logic [1:0] {
    S_FIRST  = 2'b00,
    S_SECOND = 2'b01,
    S_HOLD   = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] first_q, first_d;
  logic [DATA_WIDTH-1:0] second_q, second_d;
  logic                  pair_valid_q, pair_valid_d;
  logic                  ready;
  logic                  beat_xfer;
  logic                  hand_off;

  // Handshakes: a beat moves when data_in_valid && data_in_ready on a rising edge;
  // a pair moves when pair_valid && pair_ready. Ready never looks at valid.
  assign ready     = ((state_q == S_FIRST) || (state_q == S_SECOND)) && !flush;
  assign beat_xfer = bus.data_in_valid && ready;
  assign hand_off  = pair_valid_q && bus.pair_ready;

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    second_d     = second_q;
    pair_valid_d = pair_valid_q;
    if (flush) begin
      state_d      = S_FIRST;
      first_d      = '0;
      second_d     = '0;
      pair_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_FIRST: begin
          if (beat_xfer) begin
            first_d = bus.data_in;
            state_d = S_SECOND;
          end
        end
        S_SECOND: begin
          if (beat_xfer) begin
            second_d     = bus.data_in;
            state_d      = S_HOLD;
            pair_valid_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (hand_off) begin
            state_d      = S_FIRST;
            pair_valid_d = 1'b0;
          end
        end
        default: begin
          state_d      = S_FIRST;
          pair_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge system_clock or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state_q      <= S_FIRST;
      first_q      <= '0;
      second_q     <= '0;
      pair_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      second_q     <= second_d;
      pair_valid_q <= pair_valid_d;
    end
  end

`ifdef PAIR_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // A flushed hand-off never counts; flush leaves the running total alone.
  always_comb begin
    count_d = count_q;
    if (hand_off && !flush) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge system_clock or negedge system_rst_n) begin
    if (!system_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.pair_count = count_q;
`else
  assign bus.pair_count = {COUNT_WIDTH{1'b0}};
`endif

  assign bus.data_in_ready   = ready;
  assign bus.first_data_out  = first_q;
  assign bus.second_data_out = second_q;
  assign bus.pair_valid      = pair_valid_q;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_examp2_operand_pair_loader.sv
// Bench for examp2_operand_pair_loader: scoreboard of expected pairs plus per-scenario checks.
// Pair-count expectations follow PAIR_COUNT_EN.
module tb_examp2_operand_pair_loader;

  localparam int DW = 8;
  localparam int CW = 2;

  logic clk;
  logic rst_n;
  logic flush;
  logic [1:0] state_dbg;

  int checks;
  int failures;

  logic [2*DW-1:0] exp_q[$];
  logic [CW-1:0]   exp_count;
  logic [DW-1:0]   exp_first;
  int              beat_idx;

  examp2_operand_pair_loader_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  examp2_operand_pair_loader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .system_clock (clk),
    .system_rst_n (rst_n),
    .flush        (flush),
    .bus          (bus.slave),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    exp_q.delete();
    exp_count = '0;
    beat_idx  = 0;
    exp_first = '0;
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Sample point: checks the count every cycle and scores any hand-off due on the next edge.
  task automatic at_neg();
    logic [2*DW-1:0] exp;
    @(negedge clk);
    if (rst_n) begin
      checks++;
      if (bus.pair_count !== exp_count) begin
        failures++;
        $display("FAIL pair_count: got %0d expected %0d", bus.pair_count, exp_count);
      end
      if (bus.pair_valid && bus.pair_ready && !flush) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pair: got %h/%h with empty queue", bus.first_data_out, bus.second_data_out);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.first_data_out, bus.second_data_out} !== exp) begin
            failures++;
            $display("FAIL pair_data: got %h/%h expected %h/%h",
                     bus.first_data_out, bus.second_data_out, exp[2*DW-1:DW], exp[DW-1:0]);
          end
        end
`ifdef PAIR_COUNT_EN
        exp_count = exp_count + 1'b1;
`endif
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  // ---------------- driver ----------------
  task automatic send_beat(input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    bus.data_in       = d;
    bus.data_in_valid = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      at_neg();
      got = bus.data_in_ready;
      to_drive();
    end
    bus.data_in_valid = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL beat_timeout: beat %h not accepted within 20 cycles", d);
    end else if (beat_idx == 0) begin
      exp_first = d;
      beat_idx  = 1;
    end else begin
      exp_q.push_back({exp_first, d});
      beat_idx = 0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    at_neg();
    checks++;
    if ({bus.first_data_out, bus.second_data_out, bus.pair_valid, bus.data_in_ready, state_dbg}
        !== {8'h00, 8'h00, 1'b0, 1'b1, 2'b00}) begin
      failures++;
      $display("FAIL reset_state: got first=%h second=%h pv=%b rdy=%b st=%0d",
               bus.first_data_out, bus.second_data_out, bus.pair_valid, bus.data_in_ready, state_dbg);
    end
    to_drive();
  endtask

  task automatic test_basic();
    bus.pair_ready = 1'b1;
    send_beat(8'hA5);
    send_beat(8'h3C);
    at_neg();
    checks++;
    if ({bus.pair_valid, bus.first_data_out, bus.second_data_out, state_dbg} !== {1'b1, 8'hA5, 8'h3C, 2'b10}) begin
      failures++;
      $display("FAIL basic_latency: got pv=%b %h/%h st=%0d expected pv=1 a5/3c st=2",
               bus.pair_valid, bus.first_data_out, bus.second_data_out, state_dbg);
    end
    to_drive();
    at_neg();
    checks++;
    if ({bus.pair_valid, bus.first_data_out, bus.second_data_out, bus.data_in_ready} !== {1'b0, 8'hA5, 8'h3C, 1'b1}) begin
      failures++;
      $display("FAIL basic_one_cycle: got pv=%b %h/%h rdy=%b expected pv=0 a5/3c rdy=1",
               bus.pair_valid, bus.first_data_out, bus.second_data_out, bus.data_in_ready);
    end
    to_drive();
  endtask

  task automatic test_backpressure();
    bus.pair_ready = 1'b0;
    send_beat(8'hF0);
    send_beat(8'h0F);
    bus.data_in       = 8'h77;
    bus.data_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      checks++;
      if ({bus.data_in_ready, bus.pair_valid, bus.first_data_out, bus.second_data_out} !== {1'b0, 1'b1, 8'hF0, 8'h0F}) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: got rdy=%b pv=%b %h/%h expected rdy=0 pv=1 f0/0f",
                 i, bus.data_in_ready, bus.pair_valid, bus.first_data_out, bus.second_data_out);
      end
      to_drive();
    end
    bus.pair_ready = 1'b1;
    send_beat(8'h77);
    at_neg();
    checks++;
    if ({bus.first_data_out, state_dbg} !== {8'h77, 2'b01}) begin
      failures++;
      $display("FAIL backpressure_next: got first=%h st=%0d expected 77 st=1", bus.first_data_out, state_dbg);
    end
    to_drive();
    send_beat(8'h78);
    at_neg();
    to_drive();
  endtask

  task automatic test_flush();
    bus.pair_ready = 1'b1;
    send_beat(8'h11);
    bus.data_in       = 8'h22;
    bus.data_in_valid = 1'b1;
    flush             = 1'b1;
    at_neg();
    checks++;
    if ({bus.data_in_ready, state_dbg} !== {1'b0, 2'b01}) begin
      failures++;
      $display("FAIL flush_ready: got rdy=%b st=%0d expected rdy=0 st=1", bus.data_in_ready, state_dbg);
    end
    to_drive();
    flush             = 1'b0;
    bus.data_in_valid = 1'b0;
    beat_idx          = 0;
    at_neg();
    checks++;
    if ({bus.first_data_out, bus.second_data_out, bus.pair_valid, state_dbg} !== {8'h00, 8'h00, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL flush_clear: got %h/%h pv=%b st=%0d expected 00/00 pv=0 st=0",
               bus.first_data_out, bus.second_data_out, bus.pair_valid, state_dbg);
    end
    to_drive();
    send_beat(8'h33);
    send_beat(8'h44);
    at_neg();
    checks++;
    if (bus.pair_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_next_pair: got pv=%b expected 1", bus.pair_valid);
    end
    to_drive();
  endtask

  task automatic test_flush_vs_handoff();
    bus.pair_ready = 1'b0;
    send_beat(8'h55);
    send_beat(8'h66);
    at_neg();
    to_drive();
    bus.pair_ready = 1'b1;
    flush          = 1'b1;
    void'(exp_q.pop_back());
    at_neg();
    to_drive();
    flush          = 1'b0;
    bus.pair_ready = 1'b0;
    at_neg();
    checks++;
    if ({bus.pair_valid, state_dbg, bus.first_data_out} !== {1'b0, 2'b00, 8'h00}) begin
      failures++;
      $display("FAIL flush_vs_handoff: got pv=%b st=%0d first=%h expected pv=0 st=0 first=00",
               bus.pair_valid, state_dbg, bus.first_data_out);
    end
    to_drive();
  endtask

  task automatic test_reset_mid_op();
    send_beat(8'h99);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.first_data_out, state_dbg, bus.pair_valid} !== {8'h00, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got first=%h st=%0d pv=%b expected 00 st=0 pv=0",
               bus.first_data_out, state_dbg, bus.pair_valid);
    end
    to_drive();
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_count_wrap();
    int exp_seq[5];
`ifdef PAIR_COUNT_EN
    exp_seq = '{1, 2, 3, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif
    apply_reset();
    bus.pair_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_beat(DW'($urandom_range(0, 255)));
      send_beat(DW'($urandom_range(0, 255)));
      at_neg();
      to_drive();
      at_neg();
      checks++;
      if (bus.pair_count !== CW'(exp_seq[i])) begin
        failures++;
        $display("FAIL count_wrap[%0d]: got %0d expected %0d", i, bus.pair_count, exp_seq[i]);
      end
      to_drive();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks            = 0;
    failures          = 0;
    rst_n             = 1'b0;
    flush             = 1'b0;
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    bus.pair_ready    = 1'b0;
    model_clear();

    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_flush_vs_handoff();
    test_reset_mid_op();
    test_count_wrap();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pairs outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
